tcpc_ctrl: RTL and testbench
============================

// Module: tcpc_ctrl
// PURPOSE
// - USB Type-C Port Controller (TCPCI-style) register block reached over an I2C slave interface.
// - Sits between the system I2C bus (SCL/SDA) and the port-policy logic.
// - Exposes a byte-wide register file: ID, alert, control and status registers.
// - SCL/SDA are oversampled on CLK; the block never drives SCL.
// PARAMETERS
// - I2C_ADDR   7'h4E   7-bit slave address this block acknowledges
// - VENDOR_ID  16'h1234 value of the VENDOR_ID register pair
// - PRODUCT_ID 16'h5678 value of the PRODUCT_ID register pair
// PORTS
// - CLK    in     1  system clock; all logic on rising edge
// - RESET  in     1  reset; synchronous and active-high
// - SCL    in     1  I2C clock, driven by the bus master
// - SDA    inout  1  I2C data, open-drain: drive 1'b0 or 1'bz, never 1'b1
// BEHAVIOUR
// - Input path: SCL and SDA pass through 2-flop synchronisers, then edge detection on the synced values.
// - START = SDA falls while SCL high. STOP = SDA rises while SCL high.
// - Bus timing: SCL high and low phases are each >= 8 CLK cycles.
// - Sampling: SDA is sampled on the SCL rising edge. The block changes its SDA drive only after an SCL falling edge.
// - Reset: SDA released (z), FSM in IDLE, reg pointer = 0x00, all RW registers at reset values.
// - RESET asserted mid-transfer aborts the transfer on the next CLK.
// - START seen in any state (repeated start) -> ADDR with bit counter cleared.
// - STOP seen in any state -> IDLE with SDA released.
// - FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
// - ADDR: shift in 8 bits, MSB first.
//   - If addr[7:1] == I2C_ADDR: ACK (pull SDA low for the 9th clock).
//   - R/W=0 -> PTR; R/W=1 -> load shift register from reg[ptr] and go to RDATA.
//   - Mismatch: no ACK, go to IDLE, ignore the bus until the next START.
// - PTR: the first written byte loads the register pointer; ACK; then WDATA.
// - WDATA: each byte is ACKed and written to reg[ptr]; ptr increments by 1.
//   - The pointer wraps 0xFF -> 0x00.
//   - Writes to read-only or unmapped addresses are ACKed but have no effect.
// - RDATA: drive the 8 bits MSB first; ptr increments after each byte.
//   - The block releases SDA during the master's ACK bit.
//   - Master ACK (SDA=0) -> next byte. Master NACK -> IDLE.
//   - Unmapped addresses read 0x00.
// - Register map (address: name, access, reset value):
//   - 0x00/01: VENDOR_ID lo/hi, RO, parameter.
//   - 0x02/03: PRODUCT_ID lo/hi, RO, parameter.
//   - 0x04/05: BCD_DEVICE, RO, 0x0001.
//   - 0x06/07: TCPC_REV, RO, 0x0020.
//   - 0x10/11: ALERT lo/hi, write-1-to-clear (W1C), 0x0000. Bits are set by internal event hooks; hooks are tied 0 in this block.
//   - 0x12/13: ALERT_MASK, RW, 0x7FFF.
//   - 0x18: CONFIG_STD_OUTPUT, RW, 0x00.
//   - 0x19: TCPC_CONTROL, RW, 0x00.
//   - 0x1A: ROLE_CONTROL, RW, 0x0A.
//   - 0x1C: POWER_CONTROL, RW, 0x60.
//   - 0x1D: CC_STATUS, RO, 0x00.
//   - 0x23: COMMAND, write-only, reads 0x00.
// - A register write takes effect on the CLK after the 8th data bit is sampled. A read returns the updated value immediately afterwards.
// - A simultaneous W1C write and internal set of the same ALERT bit: the set wins.
// STRUCTURE
// - Shared package tcpc_pkg:
//   - register address localparams (REG_VENDOR_ID ... REG_COMMAND);
//   - reset-value constants;
//   - FSM state enum.
// - Sub-module i2c_slave_if: synchronisers, START/STOP detection, bit/byte FSM and SDA open-drain driver.
//   - Presents wr_en/addr/wdata and rd_req/addr/rdata to the register file in tcpc_ctrl.
// TESTING
// - Reset check:
//   - Hold RESET for 3 CLK -> SDA stays z (bus reads 1).
//   - Read 0x1A -> 0x0A; read 0x1C -> 0x60.
// - ID read:
//   - START, 0x9C (addr 0x4E, W), ptr 0x00, repeated START, 0x9D, read 4 bytes (ACK, ACK, ACK, NACK), STOP.
//   - Expect 0x34, 0x12, 0x78, 0x56, with ACK on the address and pointer bytes.
// - Wrong address:
//   - START, 0xA0 -> SDA never pulled low on the 9th clock.
//   - A following byte 0x00 is ignored; FSM returns to IDLE.
// - Write/readback with auto-increment:
//   - Write ptr 0x12, data 0xAA, 0x55, STOP.
//   - Read from 0x12 -> 0xAA, 0x55.
//   - Write 0xFF to 0x1D, then read 0x1D -> 0x00 (read-only).
// - Reset mid-transfer:
//   - Assert RESET during the 4th data bit of a read -> SDA released next CLK.
//   - The next transaction works and registers hold their reset values.
// - Pointer wrap: write ptr 0xFF, then read 2 bytes -> 0x00 (unmapped), then 0x34 (wrapped to 0x00).

Source files
------------

// File: rtl/tcpc_pkg.sv
// rtl/tcpc_pkg.sv - register map, reset values and I2C FSM states for tcpc_ctrl
package tcpc_pkg;

  localparam logic [7:0] REG_VENDOR_ID_L       = 8'h00;
  localparam logic [7:0] REG_VENDOR_ID_H       = 8'h01;
  localparam logic [7:0] REG_PRODUCT_ID_L      = 8'h02;
  localparam logic [7:0] REG_PRODUCT_ID_H      = 8'h03;
  localparam logic [7:0] REG_BCD_DEVICE_L      = 8'h04;
  localparam logic [7:0] REG_BCD_DEVICE_H      = 8'h05;
  localparam logic [7:0] REG_TCPC_REV_L        = 8'h06;
  localparam logic [7:0] REG_TCPC_REV_H        = 8'h07;
  localparam logic [7:0] REG_ALERT_L           = 8'h10;
  localparam logic [7:0] REG_ALERT_H           = 8'h11;
  localparam logic [7:0] REG_ALERT_MASK_L      = 8'h12;
  localparam logic [7:0] REG_ALERT_MASK_H      = 8'h13;
  localparam logic [7:0] REG_CONFIG_STD_OUTPUT = 8'h18;
  localparam logic [7:0] REG_TCPC_CONTROL      = 8'h19;
  localparam logic [7:0] REG_ROLE_CONTROL      = 8'h1A;
  localparam logic [7:0] REG_POWER_CONTROL     = 8'h1C;
  localparam logic [7:0] REG_CC_STATUS         = 8'h1D;
  localparam logic [7:0] REG_COMMAND           = 8'h23;

  localparam logic [15:0] BCD_DEVICE_VAL        = 16'h0001;
  localparam logic [15:0] TCPC_REV_VAL          = 16'h0020;
  localparam logic [15:0] ALERT_RST             = 16'h0000;
  localparam logic [15:0] ALERT_MASK_RST        = 16'h7FFF;
  localparam logic [7:0]  CONFIG_STD_OUTPUT_RST = 8'h00;
  localparam logic [7:0]  TCPC_CONTROL_RST      = 8'h00;
  localparam logic [7:0]  ROLE_CONTROL_RST      = 8'h0A;
  localparam logic [7:0]  POWER_CONTROL_RST     = 8'h60;
  localparam logic [7:0]  CC_STATUS_VAL         = 8'h00;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
  } i2c_state_e;

endpackage

// File: rtl/i2c_slave_if.sv
// rtl/i2c_slave_if.sv - oversampled I2C slave: sync, START/STOP, byte FSM, open-drain SDA
module i2c_slave_if
  import tcpc_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = 7'h4E
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic       wr_en,
  output logic       rd_req,
  output logic [7:0] addr,
  output logic [7:0] wdata,
  input  logic [7:0] rdata
);

  logic scl_meta, scl_sync, scl_prev;
  logic sda_meta, sda_sync, sda_prev;
  logic scl_rise, scl_fall, start_det, stop_det;

  i2c_state_e state, state_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n, ptr, ptr_n, rx_byte;
  logic       sda_oe, sda_oe_n, rw, rw_n;

  // Synchronisers idle high so a reset never fabricates a bus edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_meta <= 1'b1; scl_sync <= 1'b1; scl_prev <= 1'b1;
      sda_meta <= 1'b1; sda_sync <= 1'b1; sda_prev <= 1'b1;
    end else begin
      scl_meta <= scl;      scl_sync <= scl_meta; scl_prev <= scl_sync;
      sda_meta <= sda;      sda_sync <= sda_meta; sda_prev <= sda_sync;
    end
  end

  assign scl_rise  = scl_sync & ~scl_prev;
  assign scl_fall  = ~scl_sync & scl_prev;
  assign start_det = scl_sync & scl_prev & sda_prev & ~sda_sync;
  assign stop_det  = scl_sync & scl_prev & ~sda_prev & sda_sync;
  assign rx_byte   = {shift[6:0], sda_sync};

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      bit_cnt <= 4'd0;
      shift   <= 8'h00;
      ptr     <= 8'h00;
      sda_oe  <= 1'b0;
      rw      <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      ptr     <= ptr_n;
      sda_oe  <= sda_oe_n;
      rw      <= rw_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    ptr_n     = ptr;
    sda_oe_n  = sda_oe;
    rw_n      = rw;
    wr_en     = 1'b0;
    rd_req    = 1'b0;
    if (start_det) begin
      state_n   = ST_ADDR;
      bit_cnt_n = 4'd0;
      sda_oe_n  = 1'b0;
    end else if (stop_det) begin
      state_n  = ST_IDLE;
      sda_oe_n = 1'b0;
    end else begin
      case (state)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            shift_n   = rx_byte;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_n = 4'd0;
              if (state == ST_ADDR) begin
                if (rx_byte[7:1] == I2C_ADDR) begin
                  state_n = ST_ADDR_ACK;
                  rw_n    = rx_byte[0];
                  rd_req  = rx_byte[0];
                end else begin
                  state_n = ST_IDLE;
                end
              end else if (state == ST_PTR) begin
                ptr_n   = rx_byte;
                state_n = ST_PTR_ACK;
              end else begin
                wr_en   = 1'b1;
                ptr_n   = ptr + 8'd1;
                state_n = ST_WDATA_ACK;
              end
            end
          end
        end
        // First fall after the byte starts the ACK, the second one ends it.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_n = 1'b1;
            end else begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = 4'd0;
              if (state == ST_ADDR_ACK && rw) begin
                shift_n  = rdata;
                sda_oe_n = ~rdata[7];
                state_n  = ST_RDATA;
              end else if (state == ST_ADDR_ACK) begin
                state_n = ST_PTR;
              end else begin
                state_n = ST_WDATA;
              end
            end
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            shift_n   = {shift[6:0], 1'b0};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_n = 1'b0;
              ptr_n    = ptr + 8'd1;
              state_n  = ST_RDATA_ACK;
            end else begin
              sda_oe_n = ~shift[7];
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_sync) begin
              state_n = ST_IDLE;
            end else begin
              rd_req    = 1'b1;
              bit_cnt_n = 4'd9;
            end
          end else if (scl_fall && bit_cnt == 4'd9) begin
            shift_n   = rdata;
            sda_oe_n  = ~rdata[7];
            bit_cnt_n = 4'd0;
            state_n   = ST_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign addr  = ptr;
  assign wdata = rx_byte;
  assign sda   = sda_oe ? 1'b0 : 1'bz;

endmodule

// File: rtl/tcpc_ctrl.sv
// rtl/tcpc_ctrl.sv - TCPCI-style register block behind an I2C slave
module tcpc_ctrl
  import tcpc_pkg::*;
#(
  parameter logic [6:0]  I2C_ADDR   = 7'h4E,
  parameter logic [15:0] VENDOR_ID  = 16'h1234,
  parameter logic [15:0] PRODUCT_ID = 16'h5678
) (
  input  logic CLK,
  input  logic RESET,
  input  logic SCL,
  inout  wire  SDA
);

  logic        wr_en, rd_req;
  logic [7:0]  addr, wdata, rdata_q, rd_mux;
  logic [15:0] alert, alert_mask, alert_set, alert_clr;
  logic [7:0]  config_std_output, tcpc_control, role_control, power_control;

  i2c_slave_if #(.I2C_ADDR(I2C_ADDR)) u_i2c (
    .clk    (CLK),
    .reset  (RESET),
    .scl    (SCL),
    .sda    (SDA),
    .wr_en  (wr_en),
    .rd_req (rd_req),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata_q)
  );

  // Event hooks are not wired up in this block.
  assign alert_set = 16'h0000;

  always_comb begin
    alert_clr = 16'h0000;
    if (wr_en && addr == REG_ALERT_L) alert_clr[7:0]  = wdata;
    if (wr_en && addr == REG_ALERT_H) alert_clr[15:8] = wdata;
  end

  always_comb begin
    rd_mux = 8'h00;
    case (addr)
      REG_VENDOR_ID_L:       rd_mux = VENDOR_ID[7:0];
      REG_VENDOR_ID_H:       rd_mux = VENDOR_ID[15:8];
      REG_PRODUCT_ID_L:      rd_mux = PRODUCT_ID[7:0];
      REG_PRODUCT_ID_H:      rd_mux = PRODUCT_ID[15:8];
      REG_BCD_DEVICE_L:      rd_mux = BCD_DEVICE_VAL[7:0];
      REG_BCD_DEVICE_H:      rd_mux = BCD_DEVICE_VAL[15:8];
      REG_TCPC_REV_L:        rd_mux = TCPC_REV_VAL[7:0];
      REG_TCPC_REV_H:        rd_mux = TCPC_REV_VAL[15:8];
      REG_ALERT_L:           rd_mux = alert[7:0];
      REG_ALERT_H:           rd_mux = alert[15:8];
      REG_ALERT_MASK_L:      rd_mux = alert_mask[7:0];
      REG_ALERT_MASK_H:      rd_mux = alert_mask[15:8];
      REG_CONFIG_STD_OUTPUT: rd_mux = config_std_output;
      REG_TCPC_CONTROL:      rd_mux = tcpc_control;
      REG_ROLE_CONTROL:      rd_mux = role_control;
      REG_POWER_CONTROL:     rd_mux = power_control;
      REG_CC_STATUS:         rd_mux = CC_STATUS_VAL;
      REG_COMMAND:           rd_mux = 8'h00;
      default:               rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      alert             <= ALERT_RST;
      alert_mask        <= ALERT_MASK_RST;
      config_std_output <= CONFIG_STD_OUTPUT_RST;
      tcpc_control      <= TCPC_CONTROL_RST;
      role_control      <= ROLE_CONTROL_RST;
      power_control     <= POWER_CONTROL_RST;
      rdata_q           <= 8'h00;
    end else begin
      // Set after clear so a coincident hook event wins over W1C.
      alert <= (alert & ~alert_clr) | alert_set;
      if (wr_en) begin
        case (addr)
          REG_ALERT_MASK_L:      alert_mask[7:0]   <= wdata;
          REG_ALERT_MASK_H:      alert_mask[15:8]  <= wdata;
          REG_CONFIG_STD_OUTPUT: config_std_output <= wdata;
          REG_TCPC_CONTROL:      tcpc_control      <= wdata;
          REG_ROLE_CONTROL:      role_control      <= wdata;
          REG_POWER_CONTROL:     power_control     <= wdata;
          default: ;
        endcase
      end
      if (rd_req) rdata_q <= rd_mux;
    end
  end

endmodule

// File: tb/tb_tcpc_ctrl.sv
// tb/tb_tcpc_ctrl.sv - directed and randomized I2C transactions against a register-map model
module tb_tcpc_ctrl;

  localparam int Q = 10;

  logic clk, reset, scl, m_low;
  wire  sda;
  int   n_pass, n_total, dut_low_cnt;
  logic [7:0] exp_mem [256];
  logic [7:0] wbuf [4];

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup p_sda (sda);

  tcpc_ctrl dut (
    .CLK   (clk),
    .RESET (reset),
    .SCL   (scl),
    .SDA   (sda)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (sda === 1'b0 && !m_low) dut_low_cnt++;

  initial begin
    #900000;
    $display("FAIL watchdog: run exceeded cycle budget, observed no finish, required finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
  endtask

  // Register map as documented: fixed ID values, RW resets, everything else reads 0.
  task automatic model_reset();
    for (int a = 0; a < 256; a++) exp_mem[a] = 8'h00;
    exp_mem[8'h00] = 8'h34; exp_mem[8'h01] = 8'h12;
    exp_mem[8'h02] = 8'h78; exp_mem[8'h03] = 8'h56;
    exp_mem[8'h04] = 8'h01; exp_mem[8'h06] = 8'h20;
    exp_mem[8'h12] = 8'hFF; exp_mem[8'h13] = 8'h7F;
    exp_mem[8'h1A] = 8'h0A; exp_mem[8'h1C] = 8'h60;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    if (a inside {8'h12, 8'h13, 8'h18, 8'h19, 8'h1A, 8'h1C}) exp_mem[a] = d;
  endtask

  task automatic wbit(input logic b);
    m_low = ~b; tick(Q); scl = 1'b1; tick(2*Q); scl = 1'b0; tick(Q);
  endtask

  task automatic rbit(output logic b);
    m_low = 1'b0; tick(Q); scl = 1'b1; tick(Q); b = sda; tick(Q); scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; tick(Q); scl = 1'b1; tick(Q); m_low = 1'b1; tick(Q); scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; tick(Q); scl = 1'b1; tick(Q); m_low = 1'b0; tick(Q);
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(b);
    ack = ~b;
  endtask

  task automatic rbyte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(~ack);
  endtask

  task automatic xfer_write(input logic [7:0] ptr, input int n);
    logic ack;
    logic [7:0] p;
    p = ptr;
    i2c_start();
    wbyte(8'h9C, ack); check("wr_addr_ack", {7'b0, ack}, 8'h01);
    wbyte(ptr, ack);   check("wr_ptr_ack", {7'b0, ack}, 8'h01);
    for (int i = 0; i < n; i++) begin
      wbyte(wbuf[i], ack);
      check($sformatf("wr_data_ack_%02h", p), {7'b0, ack}, 8'h01);
      model_write(p, wbuf[i]);
      p++;
    end
    i2c_stop();
  endtask

  task automatic xfer_read(input logic [7:0] ptr, input int n);
    logic ack;
    logic [7:0] p, d;
    p = ptr;
    i2c_start();
    wbyte(8'h9C, ack); check("rd_waddr_ack", {7'b0, ack}, 8'h01);
    wbyte(ptr, ack);   check("rd_ptr_ack", {7'b0, ack}, 8'h01);
    i2c_start();
    wbyte(8'h9D, ack); check("rd_raddr_ack", {7'b0, ack}, 8'h01);
    for (int i = 0; i < n; i++) begin
      rbyte(i < n - 1, d);
      check($sformatf("rd_data_%02h", p), d, exp_mem[p]);
      p++;
    end
    i2c_stop();
  endtask

  initial begin
    logic ack, b;
    logic [7:0] picks [13];
    logic [7:0] p;
    int n, low_before;
    picks = '{8'h00, 8'h06, 8'h10, 8'h11, 8'h12, 8'h18, 8'h19,
              8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h23, 8'hFE};
    n_pass = 0; n_total = 0; dut_low_cnt = 0;
    scl = 1'b1; m_low = 1'b0; reset = 1'b1;
    model_reset();

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_sda_released", {7'b0, sda}, 8'h01);
    end
    reset = 1'b0;
    tick(Q);

    xfer_read(8'h1A, 1);
    xfer_read(8'h1C, 1);
    xfer_read(8'h00, 4);

    low_before = dut_low_cnt;
    i2c_start();
    wbyte(8'hA0, ack); check("bad_addr_nack", {7'b0, ack}, 8'h00);
    wbyte(8'h00, ack); check("bad_addr_ignored", {7'b0, ack}, 8'h00);
    i2c_stop();
    check("bad_addr_never_driven", 8'(dut_low_cnt), 8'(low_before));

    wbuf[0] = 8'hAA; wbuf[1] = 8'h55;
    xfer_write(8'h12, 2);
    xfer_read(8'h12, 2);
    wbuf[0] = 8'hFF;
    xfer_write(8'h1D, 1);
    xfer_read(8'h1D, 1);

    // Abort a read of ROLE_CONTROL while the 4th data bit is on the bus.
    wbuf[0] = 8'($urandom);
    xfer_write(8'h12, 1);
    i2c_start();
    wbyte(8'h9C, ack); check("mid_waddr_ack", {7'b0, ack}, 8'h01);
    wbyte(8'h1A, ack); check("mid_ptr_ack", {7'b0, ack}, 8'h01);
    i2c_start();
    wbyte(8'h9D, ack); check("mid_raddr_ack", {7'b0, ack}, 8'h01);
    for (int i = 0; i < 3; i++) rbit(b);
    m_low = 1'b0; tick(Q); scl = 1'b1; tick(Q);
    check("mid_bit4_driven", {7'b0, sda}, {7'b0, exp_mem[8'h1A][4]});
    reset = 1'b1;
    tick(1);
    check("mid_reset_release", {7'b0, sda}, 8'h01);
    reset = 1'b0;
    tick(Q); scl = 1'b0; tick(Q);
    i2c_stop();
    model_reset();
    xfer_read(8'h12, 2);
    xfer_read(8'h1A, 1);

    for (int it = 0; it < 5; it++) begin
      p = picks[$urandom_range(0, 12)];
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      xfer_write(p, n);
      xfer_read(p, n + 1);
    end

    xfer_write(8'hFF, 0);
    xfer_read(8'hFF, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
